io_regs: RTL and testbench
==========================

# io_regs

Parametrised memory-mapped I/O register block sitting on the non-memory half of the CPU data bus, next to the SPI flash/RAM path. It decodes byte-offset register accesses for output, input and bidirectional GPIO of configurable width, fronts an external UART byte engine with a receive FIFO, and adds a free-running timer with compare. It uses the same level-held `start_request` / `request_done` handshake as the rest of the bus.

## Interface
- `OUT_WIDTH`, 4: output-only pins, 1..8.
- `IN_WIDTH`, 5: input-only pins, 1..8.
- `IO_WIDTH`, 7: bidirectional pins, 1..8.
- `RX_FIFO_DEPTH`, 4: UART receive FIFO entries, power of two, 2..16.
- `TIMER_WIDTH`, 24: timer and compare width, 8..32.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start_request` in 1: request valid, held high until `request_done` is seen.
- `is_write` in 1: 1 = write, 0 = read.
- `target_address` in 8: register byte offset.
- `write_value` in 32: write data.
- `fetched_value` out 32: read data, zero-extended.
- `request_done` out 1: request complete.
- `outputs` out OUT_WIDTH: output pins.
- `inputs` in IN_WIDTH: asynchronous input pins.
- `io_direction` out IO_WIDTH: 1 = pin drives.
- `io_outputs` out IO_WIDTH: drive values.
- `io_inputs` in IO_WIDTH: asynchronous pin values.
- `uart_tx_byte` out 8: byte to transmit.
- `uart_start_tx` out 1: level, held until `uart_tx_done`.
- `uart_tx_done` in 1: transmit finished.
- `uart_rx_valid` in 1: one-cycle pulse, received byte available.
- `uart_rx_byte` in 8: received byte.
- `uart_counter_end` out 12: baud divider.
- `irq` out 1: interrupt, level.

## Operation
Register map. Unlisted offsets read 0; writes to them are ignored.
- 0x00 OUT, rw.
- 0x01 IN, ro: inputs after a 2-flop synchroniser.
- 0x02 IO_DIR, rw.
- 0x03 IO_IN, ro: synchronised `io_inputs & ~IO_DIR`.
- 0x04 IO_OUT, rw: stores `write_value & IO_DIR`.
- 0x05 IO_SET, wo: `IO_OUT |= wv & IO_DIR`.
- 0x06 IO_CLR, wo: `IO_OUT &= ~wv`.
- 0x10 UART_CTRL, wo:
  - bit0 start TX. Ignored while `uart_start_tx` = 1.
  - bit1 flush RX FIFO and clear overflow.
- 0x11 UART_STAT, ro: bit0 TX busy, bit1 RX not empty, bit2 RX full, bit3 overflow (sticky).
- 0x14 UART_TX, rw: the `uart_tx_byte` value.
- 0x15 UART_RX, ro:
  - Returns the FIFO head and pops it.
  - When empty, returns 0 and does not pop.
- 0x16 UART_BAUD, rw: 12 bits.
- 0x18 RX_COUNT, ro: FIFO occupancy, 0..`RX_FIFO_DEPTH`.
- 0x20 TIMER, ro: current count.
- 0x24 TIMER_CMP, rw.
- 0x28 TIMER_CTRL:
  - bit0 enable, rw.
  - bit1 clear, write-1 pulse, reads 0.

Request state machine: IDLE, DONE.
- IDLE with `start_request` = 1: perform the access, register `fetched_value`, go to DONE.
- DONE: `request_done` = 1. Return to IDLE on the cycle after `start_request` = 0.
- Each request has exactly one side effect, even if `start_request` stays high for many cycles.

UART:
- `uart_start_tx` is cleared on `uart_tx_done`.
- A `uart_rx_valid` pulse pushes into the FIFO.
- Push while full drops the byte and sets overflow, unless a pop happens in the same cycle; then the push is accepted.
- Simultaneous push and pop leaves the count unchanged.
- Flush in the same cycle as a push: flush wins and the byte is dropped.

Timer:
- Increments by 1 per cycle while enabled, wrapping from all-ones to 0.
- A clear write forces 0 and takes priority over increment.
- Match means count == TIMER_CMP while enabled.

## Timing
- Access latency: `request_done` and `fetched_value` are valid 1 cycle after `start_request` is first sampled high. Both are held until `start_request` falls.
- `request_done` = 0 in the cycle after `start_request` falls. The next request can be accepted the cycle after that.
- Writes take effect on the DONE entry edge. Pins reflect the new value in that same cycle.
- IN and IO_IN latency from pin to readable value: 2 cycles.
- Reset values:
  - All outputs 0, including `fetched_value`, `request_done`, `irq` and `uart_start_tx`.
  - Exception: `uart_counter_end` = 1250.
  - Internally: FIFO empty, overflow 0, timer 0 and disabled, state IDLE.
- Reset mid-request: return to IDLE. A pending side effect is discarded.

## Configuration
- `IO_REGS_IRQ_EN` defined:
  - Adds 0x2C IRQ_EN, rw, and 0x2D IRQ_PEND, read / write-1-to-clear.
  - IRQ_PEND bit0 = RX not empty, level, not clearable while the condition holds.
  - IRQ_PEND bit1 = timer match, sticky.
  - IRQ_PEND bit2 = rising edge on any synchronised IO_IN bit, sticky.
  - `irq` = |(IRQ_PEND & IRQ_EN), registered, 1-cycle delay.
  - A set and a clear in the same cycle: set wins.
- Not defined:
  - 0x2C and 0x2D read 0 and ignore writes.
  - `irq` is tied to 0.
  - No edge-detect or pending logic is present.

## Test plan
- Reset, then read 0x16 → `fetched_value` = 1250. `request_done` is high 1 cycle after request and stays high while `start_request` is held for 5 cycles.
- Write IO_DIR = 0x0F, IO_OUT = 0x7F → `io_outputs` = 0x0F. IO_SET 0x70 → 0x0F. IO_CLR 0x01 → 0x0E.
- Drive 5 RX pulses (0xA1..0xA5), depth 4 → RX_COUNT = 4 and overflow = 1. Four UART_RX reads return 0xA1..0xA4; a fifth read returns 0 with count 0.
- RX push and UART_RX pop in the same cycle with FIFO full → count stays 4 and no overflow.
- Write UART_TX = 0x55, CTRL bit0 → `uart_start_tx` = 1 and `uart_tx_byte` = 0x55. A second start while busy is ignored. `uart_tx_done` → `uart_start_tx` = 0 next cycle.
- With `IO_REGS_IRQ_EN`: TIMER_CMP = 10, enable, IRQ_EN = 0x2 → `irq` high 12 cycles after enable. Write IRQ_PEND 0x2 → `irq` low next cycle.

Source files
------------

// File: rtl/io_regs_if.sv
// io_regs_if: CPU data-bus request channel for the io_regs block.
//
// Handshake: the master raises start_request with is_write, target_address
// and write_value stable, and holds all of them until it sees request_done.
// The slave performs the access exactly once, on the first cycle it samples
// start_request high, then holds request_done and fetched_value until
// start_request falls. request_done drops the cycle after that, and a new
// request may be raised the cycle after request_done has dropped.
// dbg_state mirrors the slave's request FSM state (0 = IDLE, 1 = DONE).
`timescale 1ns/1ps
interface io_regs_if;
  logic        start_request;
  logic        is_write;
  logic [7:0]  target_address;
  logic [31:0] write_value;
  logic [31:0] fetched_value;
  logic        request_done;
  logic        dbg_state;

  modport master (
    output start_request, is_write, target_address, write_value,
    input  fetched_value, request_done, dbg_state
  );

  modport slave (
    input  start_request, is_write, target_address, write_value,
    output fetched_value, request_done, dbg_state
  );
endinterface

// File: rtl/io_regs.sv
// io_regs: memory-mapped GPIO / UART front-end / timer register block.
// Optional interrupt logic (IRQ_EN / IRQ_PEND registers and the irq output)
// is compiled in when the macro IO_REGS_IRQ_EN is defined; otherwise irq is 0.
`timescale 1ns/1ps
module io_regs #(
  parameter int OUT_WIDTH     = 4,
  parameter int IN_WIDTH      = 5,
  parameter int IO_WIDTH      = 7,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int TIMER_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  io_regs_if.slave             bus,
  output logic [OUT_WIDTH-1:0] outputs,
  input  logic [IN_WIDTH-1:0]  inputs,
  output logic [IO_WIDTH-1:0]  io_direction,
  output logic [IO_WIDTH-1:0]  io_outputs,
  input  logic [IO_WIDTH-1:0]  io_inputs,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_start_tx,
  input  logic                 uart_tx_done,
  input  logic                 uart_rx_valid,
  input  logic [7:0]           uart_rx_byte,
  output logic [11:0]          uart_counter_end,
  output logic                 irq
);

  localparam int PW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        accept, wr_en, rd_en;
  logic [7:0]  addr;
  logic [31:0] wv;
  logic [31:0] rdata;
  logic [31:0] fetched_q;

  logic [OUT_WIDTH-1:0] out_q;
  logic [IO_WIDTH-1:0]  io_dir_q, io_out_q;
  logic [IN_WIDTH-1:0]  in_s1_q, in_s2_q;
  logic [IO_WIDTH-1:0]  io_s1_q, io_s2_q;

  logic [7:0]  tx_byte_q;
  logic        start_tx_q;
  logic [11:0] baud_q;

  logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic        ovf_q;
  logic        fifo_empty, fifo_full, pop, flush, push_ok;
  logic [7:0]  fifo_head;

  logic [TIMER_WIDTH-1:0] timer_q, cmp_q;
  logic        tmr_en_q;

  logic [2:0]  irq_en_rd, irq_pend_rd;
  logic        unused_bits;

  // A request is accepted only from IDLE, so a held start_request causes one access.
  assign accept = (state_q == ST_IDLE) && bus.start_request;
  assign wr_en  = accept && bus.is_write;
  assign rd_en  = accept && !bus.is_write;
  assign addr   = bus.target_address;
  assign wv     = bus.write_value;
  assign unused_bits = ^wv;

  // Request FSM next state: IDLE -> DONE on accept, DONE -> IDLE once start_request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_request) state_d = ST_DONE;
      ST_DONE: if (!bus.start_request) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request FSM state and the registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fetched_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) fetched_q <= bus.is_write ? 32'h0 : rdata;
    end
  end

  assign bus.request_done  = (state_q == ST_DONE);
  assign bus.fetched_value = fetched_q;
  assign bus.dbg_state     = state_q;

  // Two-flop synchronisers for the asynchronous input pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_s1_q <= '0;
      in_s2_q <= '0;
      io_s1_q <= '0;
      io_s2_q <= '0;
    end else begin
      in_s1_q <= inputs;
      in_s2_q <= in_s1_q;
      io_s1_q <= io_inputs;
      io_s2_q <= io_s1_q;
    end
  end

  // GPIO registers; IO_OUT bits can only be set where the pin is an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      io_dir_q <= '0;
      io_out_q <= '0;
    end else if (wr_en) begin
      case (addr)
        8'h00: out_q    <= wv[OUT_WIDTH-1:0];
        8'h02: io_dir_q <= wv[IO_WIDTH-1:0];
        8'h04: io_out_q <= wv[IO_WIDTH-1:0] & io_dir_q;
        8'h05: io_out_q <= io_out_q | (wv[IO_WIDTH-1:0] & io_dir_q);
        8'h06: io_out_q <= io_out_q & ~wv[IO_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign outputs      = out_q;
  assign io_direction = io_dir_q;
  assign io_outputs   = io_out_q;

  // UART transmit side: byte, baud divider and the start level held until tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte_q  <= '0;
      start_tx_q <= 1'b0;
      baud_q     <= 12'd1250;
    end else begin
      if (wr_en && addr == 8'h14) tx_byte_q <= wv[7:0];
      if (wr_en && addr == 8'h16) baud_q    <= wv[11:0];
      if (start_tx_q) begin
        if (uart_tx_done) start_tx_q <= 1'b0;
      end else if (wr_en && addr == 8'h10 && wv[0]) begin
        start_tx_q <= 1'b1;
      end
    end
  end

  assign uart_tx_byte     = tx_byte_q;
  assign uart_start_tx    = start_tx_q;
  assign uart_counter_end = baud_q;

  // Receive FIFO control. A pop in the same cycle frees the slot for a push;
  // a flush overrides everything, including a same-cycle push.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(RX_FIFO_DEPTH));
  assign pop        = rd_en && addr == 8'h15 && !fifo_empty;
  assign flush      = wr_en && addr == 8'h10 && wv[1];
  assign push_ok    = uart_rx_valid && (!fifo_full || pop);
  assign fifo_head  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  // FIFO storage, written only for accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) fifo_mem[wr_ptr_q] <= uart_rx_byte;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (uart_rx_valid && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Free-running timer; a clear write beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= '0;
      cmp_q    <= '0;
      tmr_en_q <= 1'b0;
    end else begin
      if (wr_en && addr == 8'h24) cmp_q <= wv[TIMER_WIDTH-1:0];
      if (wr_en && addr == 8'h28) tmr_en_q <= wv[0];
      if (wr_en && addr == 8'h28 && wv[1]) timer_q <= '0;
      else if (tmr_en_q)                   timer_q <= timer_q + 1'b1;
    end
  end

`ifdef IO_REGS_IRQ_EN
  logic [2:0]          irq_en_q;
  logic                pend_match_q, pend_edge_q, irq_q;
  logic [IO_WIDTH-1:0] io_in_prev_q, io_in_cur;
  logic                io_rise, tmr_match, pend_wr;
  logic [2:0]          pend;

  assign io_in_cur = io_s2_q & ~io_dir_q;
  assign io_rise   = |(io_in_cur & ~io_in_prev_q);
  assign tmr_match = tmr_en_q && (timer_q == cmp_q);
  assign pend_wr   = wr_en && addr == 8'h2D;
  assign pend      = {pend_edge_q, pend_match_q, !fifo_empty};

  // Pending flags: sticky sources with write-1-to-clear, where a new event wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q     <= '0;
      pend_match_q <= 1'b0;
      pend_edge_q  <= 1'b0;
      io_in_prev_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      io_in_prev_q <= io_in_cur;
      if (wr_en && addr == 8'h2C) irq_en_q <= wv[2:0];
      pend_match_q <= tmr_match | (pend_match_q & ~(pend_wr & wv[1]));
      pend_edge_q  <= io_rise   | (pend_edge_q  & ~(pend_wr & wv[2]));
      irq_q        <= |(pend & irq_en_q);
    end
  end

  assign irq         = irq_q;
  assign irq_en_rd   = irq_en_q;
  assign irq_pend_rd = pend;
`else
  assign irq         = 1'b0;
  assign irq_en_rd   = 3'b000;
  assign irq_pend_rd = 3'b000;
`endif

  // Read data mux; unlisted offsets read 0.
  always_comb begin
    rdata = '0;
    case (addr)
      8'h00: rdata[OUT_WIDTH-1:0]   = out_q;
      8'h01: rdata[IN_WIDTH-1:0]    = in_s2_q;
      8'h02: rdata[IO_WIDTH-1:0]    = io_dir_q;
      8'h03: rdata[IO_WIDTH-1:0]    = io_s2_q & ~io_dir_q;
      8'h04: rdata[IO_WIDTH-1:0]    = io_out_q;
      8'h11: rdata[3:0]             = {ovf_q, fifo_full, !fifo_empty, start_tx_q};
      8'h14: rdata[7:0]             = tx_byte_q;
      8'h15: rdata[7:0]             = fifo_head;
      8'h16: rdata[11:0]            = baud_q;
      8'h18: rdata[CW-1:0]          = count_q;
      8'h20: rdata[TIMER_WIDTH-1:0] = timer_q;
      8'h24: rdata[TIMER_WIDTH-1:0] = cmp_q;
      8'h28: rdata[0]               = tmr_en_q;
      8'h2C: rdata[2:0]             = irq_en_rd;
      8'h2D: rdata[2:0]             = irq_pend_rd;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_regs.sv
// tb_io_regs: randomized self-checking bench for io_regs with a queue-based
// reference model of the receive FIFO and plain-variable models of the registers.
`timescale 1ns/1ps
module tb_io_regs;
  localparam int OUT_W = 4;
  localparam int IN_W  = 5;
  localparam int IO_W  = 7;
  localparam int DEPTH = 4;
  localparam int TW    = 24;

  // ---------------- clock / reset ----------------
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  io_regs_if bus();
  logic [OUT_W-1:0] outputs;
  logic [IN_W-1:0]  inputs;
  logic [IO_W-1:0]  io_direction, io_outputs, io_inputs;
  logic [7:0]       uart_tx_byte, uart_rx_byte;
  logic             uart_start_tx, uart_tx_done, uart_rx_valid, irq;
  logic [11:0]      uart_counter_end;

  io_regs #(.OUT_WIDTH(OUT_W), .IN_WIDTH(IN_W), .IO_WIDTH(IO_W),
            .RX_FIFO_DEPTH(DEPTH), .TIMER_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .outputs(outputs), .inputs(inputs),
    .io_direction(io_direction), .io_outputs(io_outputs), .io_inputs(io_inputs),
    .uart_tx_byte(uart_tx_byte), .uart_start_tx(uart_start_tx), .uart_tx_done(uart_tx_done),
    .uart_rx_valid(uart_rx_valid), .uart_rx_byte(uart_rx_byte),
    .uart_counter_end(uart_counter_end), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model state ----------------
  logic [OUT_W-1:0] m_out;
  logic [IO_W-1:0]  m_dir, m_io_out;
  logic [7:0]       m_rx_q[$];
  logic             m_ovf;

  // ---------------- driver tasks ----------------
  task automatic bus_op(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic rx_pulse, input logic [7:0] rx_b,
                        output logic [31:0] rdata, output int acc);
    int waited;
    @(negedge clk);
    bus.start_request  = 1'b1;
    bus.is_write       = wr;
    bus.target_address = addr;
    bus.write_value    = data;
    if (rx_pulse) begin
      uart_rx_valid = 1'b1;
      uart_rx_byte  = rx_b;
    end
    waited = 0;
    do begin
      @(negedge clk);
      uart_rx_valid = 1'b0;
      waited++;
    end while (!bus.request_done && waited < 20);
    n_checks++;
    if (bus.request_done !== 1'b1)
      $display("FAIL bus_done addr=%02h: got %b, want 1", addr, bus.request_done);
    else n_pass++;
    rdata = bus.fetched_value;
    acc   = cyc;
    bus.start_request = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.request_done !== 1'b0)
      $display("FAIL bus_done_drop addr=%02h: got %b, want 0", addr, bus.request_done);
    else n_pass++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    int c;
    bus_op(1'b1, a, d, 1'b0, 8'h00, r, c);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    int c;
    bus_op(1'b0, a, 32'h0, 1'b0, 8'h00, r, c);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_byte  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({outputs, io_direction, io_outputs, uart_tx_byte, uart_start_tx, irq} !== '0)
      $display("FAIL reset_pins: got %h, want 0",
               {outputs, io_direction, io_outputs, uart_tx_byte, uart_start_tx, irq});
    else n_pass++;
    n_checks++;
    if (uart_counter_end !== 12'd1250)
      $display("FAIL reset_baud: got %0d, want 1250", uart_counter_end);
    else n_pass++;
    n_checks++;
    if (bus.request_done !== 1'b0 || bus.fetched_value !== 32'h0)
      $display("FAIL reset_bus: got done=%b data=%h, want 0/0", bus.request_done, bus.fetched_value);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    // Read baud with start_request held for 5 cycles.
    bus.start_request = 1'b1; bus.is_write = 1'b0; bus.target_address = 8'h16;
    @(negedge clk);
    n_checks++;
    if (bus.request_done !== 1'b1 || bus.fetched_value !== 32'd1250)
      $display("FAIL reset_read_baud: got done=%b data=%0d, want 1/1250", bus.request_done, bus.fetched_value);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.request_done !== 1'b1 || bus.fetched_value !== 32'd1250)
        $display("FAIL held_done cycle %0d: got done=%b data=%0d, want 1/1250", i, bus.request_done, bus.fetched_value);
      else n_pass++;
    end
    bus.start_request = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.request_done !== 1'b0)
      $display("FAIL held_done_drop: got %b, want 0", bus.request_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    // A write accepted on a reset edge must have no effect.
    @(negedge clk);
    bus.start_request = 1'b1; bus.is_write = 1'b1; bus.target_address = 8'h00; bus.write_value = 32'hF;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outputs !== '0 || bus.request_done !== 1'b0)
      $display("FAIL reset_mid: got out=%h done=%b, want 0/0", outputs, bus.request_done);
    else n_pass++;
    bus.start_request = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outputs !== '0)
      $display("FAIL reset_mid_after: got out=%h, want 0", outputs);
    else n_pass++;
    m_out = '0; m_dir = '0; m_io_out = '0;
  endtask

  task automatic test_gpio_plan();
    wr(8'h02, 32'h0F); m_dir = 7'h0F;
    wr(8'h04, 32'h7F); m_io_out = 7'h0F;
    n_checks++;
    if (io_outputs !== 7'h0F) $display("FAIL gpio_io_out: got %h, want 0f", io_outputs); else n_pass++;
    wr(8'h05, 32'h70);
    n_checks++;
    if (io_outputs !== 7'h0F) $display("FAIL gpio_io_set: got %h, want 0f", io_outputs); else n_pass++;
    wr(8'h06, 32'h01); m_io_out = 7'h0E;
    n_checks++;
    if (io_outputs !== 7'h0E) $display("FAIL gpio_io_clr: got %h, want 0e", io_outputs); else n_pass++;
  endtask

  task automatic test_gpio_random();
    logic [31:0] d, r;
    int op;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 4);
      d  = $urandom;
      case (op)
        0: begin wr(8'h00, d); m_out = d[OUT_W-1:0]; end
        1: begin wr(8'h02, d); m_dir = d[IO_W-1:0]; end
        2: begin wr(8'h04, d); m_io_out = d[IO_W-1:0] & m_dir; end
        3: begin wr(8'h05, d); m_io_out = m_io_out | (d[IO_W-1:0] & m_dir); end
        default: begin wr(8'h06, d); m_io_out = m_io_out & ~d[IO_W-1:0]; end
      endcase
      n_checks++;
      if ({outputs, io_direction, io_outputs} !== {m_out, m_dir, m_io_out})
        $display("FAIL gpio_rand op%0d: got out=%h dir=%h io=%h, want %h %h %h",
                 op, outputs, io_direction, io_outputs, m_out, m_dir, m_io_out);
      else n_pass++;
    end
    rd(8'h00, r);
    n_checks++;
    if (r !== 32'(m_out)) $display("FAIL read_out: got %h, want %h", r, m_out); else n_pass++;
    rd(8'h02, r);
    n_checks++;
    if (r !== 32'(m_dir)) $display("FAIL read_dir: got %h, want %h", r, m_dir); else n_pass++;
    rd(8'h04, r);
    n_checks++;
    if (r !== 32'(m_io_out)) $display("FAIL read_io_out: got %h, want %h", r, m_io_out); else n_pass++;
    wr(8'h07, 32'hFFFF_FFFF);
    wr(8'h30, 32'hFFFF_FFFF);
    rd(8'h07, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL unmapped_07: got %h, want 0", r); else n_pass++;
    rd(8'h30, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL unmapped_30: got %h, want 0", r); else n_pass++;
  endtask

  task automatic test_inputs_sync();
    logic [IN_W-1:0] old_in, v;
    logic [IO_W-1:0] iov;
    logic [31:0] r;
    old_in = inputs;
    for (int i = 0; i < 4; i++) begin
      v   = IN_W'($urandom);
      iov = IO_W'($urandom);
      @(negedge clk);
      inputs    = v;
      io_inputs = iov;
      rd(8'h01, r);  // pin changed only one cycle before the access edge
      n_checks++;
      if (r !== 32'(old_in)) $display("FAIL in_latency: got %h, want old %h", r, old_in); else n_pass++;
      rd(8'h01, r);
      n_checks++;
      if (r !== 32'(v)) $display("FAIL in_value: got %h, want %h", r, v); else n_pass++;
      rd(8'h03, r);
      n_checks++;
      if (r !== 32'(iov & ~m_dir)) $display("FAIL io_in_value: got %h, want %h", r, iov & ~m_dir); else n_pass++;
      old_in = v;
    end
  endtask

  task automatic test_uart_tx();
    logic [31:0] r;
    wr(8'h14, 32'h55);
    wr(8'h10, 32'h1);
    n_checks++;
    if (uart_start_tx !== 1'b1 || uart_tx_byte !== 8'h55)
      $display("FAIL tx_start: got start=%b byte=%h, want 1/55", uart_start_tx, uart_tx_byte);
    else n_pass++;
    rd(8'h11, r);
    n_checks++;
    if (r !== 32'h1) $display("FAIL tx_stat_busy: got %h, want 1", r); else n_pass++;
    wr(8'h14, 32'h66);
    wr(8'h10, 32'h1);  // ignored while busy
    rd(8'h14, r);
    n_checks++;
    if (r !== 32'h66 || uart_start_tx !== 1'b1)
      $display("FAIL tx_busy_restart: got byte=%h start=%b, want 66/1", r, uart_start_tx);
    else n_pass++;
    @(negedge clk);
    uart_tx_done = 1'b1;
    @(negedge clk);
    uart_tx_done = 1'b0;
    n_checks++;
    if (uart_start_tx !== 1'b0) $display("FAIL tx_done_clear: got %b, want 0", uart_start_tx); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uart_start_tx !== 1'b0) $display("FAIL tx_no_retrigger: got %b, want 0", uart_start_tx); else n_pass++;
  endtask

  task automatic test_fifo_plan();
    logic [31:0] r;
    logic [7:0] b;
    int c;
    wr(8'h10, 32'h2);
    for (int i = 0; i < 5; i++) begin
      b = 8'hA1 + 8'(i);
      rx_push(b);
    end
    rd(8'h18, r);
    n_checks++;
    if (r !== 32'd4) $display("FAIL fifo_count_full: got %0d, want 4", r); else n_pass++;
    rd(8'h11, r);
    n_checks++;
    if (r !== 32'hE) $display("FAIL fifo_stat_ovf: got %h, want e", r); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd(8'h15, r);
      n_checks++;
      if (r !== 32'hA1 + i) $display("FAIL fifo_pop%0d: got %h, want %h", i, r, 32'hA1 + i); else n_pass++;
    end
    rd(8'h15, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL fifo_pop_empty: got %h, want 0", r); else n_pass++;
    rd(8'h18, r);
    n_checks++;
    if (r !== 32'd0) $display("FAIL fifo_count_empty: got %0d, want 0", r); else n_pass++;
    rd(8'h11, r);
    n_checks++;
    if (r !== 32'h8) $display("FAIL fifo_ovf_sticky: got %h, want 8", r); else n_pass++;
    wr(8'h10, 32'h2);
    rd(8'h11, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL fifo_flush_stat: got %h, want 0", r); else n_pass++;
    // Full FIFO: a push in the same cycle as a pop is accepted.
    for (int i = 0; i < 4; i++) begin
      b = 8'hB0 + 8'(i);
      rx_push(b);
    end
    bus_op(1'b0, 8'h15, 32'h0, 1'b1, 8'hB4, r, c);
    n_checks++;
    if (r !== 32'hB0) $display("FAIL fifo_pushpop_data: got %h, want b0", r); else n_pass++;
    rd(8'h18, r);
    n_checks++;
    if (r !== 32'd4) $display("FAIL fifo_pushpop_count: got %0d, want 4", r); else n_pass++;
    rd(8'h11, r);
    n_checks++;
    if (r !== 32'h6) $display("FAIL fifo_pushpop_stat: got %h, want 6", r); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      rd(8'h15, r);
      n_checks++;
      if (r !== 32'hB0 + i) $display("FAIL fifo_drain%0d: got %h, want %h", i, r, 32'hB0 + i); else n_pass++;
    end
    // Flush wins over a same-cycle push.
    bus_op(1'b1, 8'h10, 32'h2, 1'b1, 8'hCC, r, c);
    rd(8'h18, r);
    n_checks++;
    if (r !== 32'd0) $display("FAIL fifo_flush_push: got %0d, want 0", r); else n_pass++;
  endtask

  task automatic test_fifo_random();
    logic [31:0] r, exp;
    logic [7:0] b;
    int k, c;
    wr(8'h10, 32'h2);
    m_rx_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      b = 8'($urandom);
      if (k == 0) begin
        rx_push(b);
        if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b); else m_ovf = 1'b1;
      end else begin
        exp = (m_rx_q.size() != 0) ? 32'(m_rx_q[0]) : 32'h0;
        bus_op(1'b0, 8'h15, 32'h0, (k == 2), b, r, c);
        if (m_rx_q.size() != 0) void'(m_rx_q.pop_front());
        if (k == 2) begin
          if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b); else m_ovf = 1'b1;
        end
        n_checks++;
        if (r !== exp) $display("FAIL fifo_rand_pop it%0d: got %h, want %h", i, r, exp); else n_pass++;
      end
      rd(8'h18, r);
      n_checks++;
      if (r !== 32'(m_rx_q.size()))
        $display("FAIL fifo_rand_count it%0d: got %0d, want %0d", i, r, m_rx_q.size());
      else n_pass++;
    end
    rd(8'h11, r);
    exp = {28'h0, m_ovf, (m_rx_q.size() == DEPTH), (m_rx_q.size() != 0), 1'b0};
    n_checks++;
    if (r !== exp) $display("FAIL fifo_rand_stat: got %h, want %h", r, exp); else n_pass++;
  endtask

  task automatic test_timer();
    logic [31:0] r, cmpv;
    int c0, c1, c2, c3, c4, c5;
    cmpv = 32'($urandom_range(0, (1 << TW) - 1));
    wr(8'h24, cmpv);
    rd(8'h24, r);
    n_checks++;
    if (r !== cmpv) $display("FAIL timer_cmp: got %h, want %h", r, cmpv); else n_pass++;
    rd(8'h20, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL timer_idle: got %0d, want 0", r); else n_pass++;
    bus_op(1'b1, 8'h28, 32'h3, 1'b0, 8'h0, r, c0);
    repeat ($urandom_range(0, 7)) @(negedge clk);
    bus_op(1'b0, 8'h20, 32'h0, 1'b0, 8'h0, r, c1);
    n_checks++;
    if (r !== 32'(c1 - c0 - 1)) $display("FAIL timer_count: got %0d, want %0d", r, c1 - c0 - 1); else n_pass++;
    rd(8'h28, r);
    n_checks++;
    if (r !== 32'h1) $display("FAIL timer_ctrl_read: got %h, want 1", r); else n_pass++;
    bus_op(1'b1, 8'h28, 32'h3, 1'b0, 8'h0, r, c2);
    repeat ($urandom_range(0, 7)) @(negedge clk);
    bus_op(1'b0, 8'h20, 32'h0, 1'b0, 8'h0, r, c3);
    n_checks++;
    if (r !== 32'(c3 - c2 - 1)) $display("FAIL timer_clear: got %0d, want %0d", r, c3 - c2 - 1); else n_pass++;
    bus_op(1'b1, 8'h28, 32'h0, 1'b0, 8'h0, r, c4);
    repeat (5) @(negedge clk);
    bus_op(1'b0, 8'h20, 32'h0, 1'b0, 8'h0, r, c5);
    n_checks++;
    if (r !== 32'(c4 - c2)) $display("FAIL timer_frozen: got %0d, want %0d", r, c4 - c2); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] r;
`ifdef IO_REGS_IRQ_EN
    int ce, seen, c;
    wr(8'h2C, 32'h2);
    wr(8'h24, 32'd10);
    bus_op(1'b1, 8'h28, 32'h3, 1'b0, 8'h0, r, ce);
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = cyc - ce;
    end
    n_checks++;
    if (seen != 12) $display("FAIL irq_timer_delay: got %0d cycles, want 12", seen); else n_pass++;
    bus_op(1'b1, 8'h2D, 32'h2, 1'b0, 8'h0, r, c);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b, want 0", irq); else n_pass++;
    rd(8'h2C, r);
    n_checks++;
    if (r !== 32'h2) $display("FAIL irq_en_read: got %h, want 2", r); else n_pass++;
`else
    wr(8'h2C, 32'h7);
    rd(8'h2C, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL irq_en_absent: got %h, want 0", r); else n_pass++;
    rd(8'h2D, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL irq_pend_absent: got %h, want 0", r); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_tied: got %b, want 0", irq); else n_pass++;
`endif
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.start_request = 1'b0; bus.is_write = 1'b0;
    bus.target_address = 8'h00; bus.write_value = 32'h0;
    inputs = '0; io_inputs = '0;
    uart_tx_done = 1'b0; uart_rx_valid = 1'b0; uart_rx_byte = 8'h00;
    m_out = '0; m_dir = '0; m_io_out = '0; m_ovf = 1'b0;
    test_reset();
    test_reset_mid();
    test_gpio_plan();
    test_gpio_random();
    test_inputs_sync();
    test_uart_tx();
    test_fifo_plan();
    test_fifo_random();
    test_timer();
    test_irq();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
